vec_mem_sequencer: RTL and testbench

//  Sequences the four byte-wide memory accesses of a vector load/store for the

---
 rtl/vec_mem_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_sequencer.sv
// Sequences the byte-wide memory accesses of a vector load/store over an 8-bit memory port.
// Optional VSEQ_WRAP_CHK_EN: flag transfers that cross the top address (addr_wrap with done).
module vec_mem_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int LANES    = 4,
    parameter int READ_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op_store,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [8*LANES-1:0]   store_data,
    output logic                 busy,
    output logic                 done,
    output logic [8*LANES-1:0]   load_data,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rden,
    output logic                 mem_wren,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_q,
    output logic                 addr_wrap
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [LW-1:0]       lane_r;
    logic [1:0]          drain_cnt_r;
    logic                op_store_r;
    logic [ADDR_W-1:0]   base_r;
    logic [8*LANES-1:0]  store_r;
    logic                wrap_r;
    logic                wrap_s;
    logic [LW-1:0]       lane_nxt_s;
    logic                cap_vld_s;
    logic [LW-1:0]       cap_lane_s;

    assign lane_nxt_s = lane_r + LW'(1);

`ifdef VSEQ_WRAP_CHK_EN
    logic [ADDR_W:0] last_addr_s;
    // Carry out of base + LANES-1 means the transfer crosses the top address.
    assign last_addr_s = {1'b0, base_addr} + (ADDR_W+1)'(LANES - 1);
    assign wrap_s      = last_addr_s[ADDR_W];
`else
    assign wrap_s = 1'b0;
`endif

    // Control FSM with registered memory-port and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            lane_r      <= '0;
            drain_cnt_r <= 2'd0;
            op_store_r  <= 1'b0;
            base_r      <= '0;
            store_r     <= '0;
            wrap_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            addr_wrap   <= 1'b0;
            mem_addr    <= '0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            mem_wdata   <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= ISSUE;
                        busy       <= 1'b1;
                        op_store_r <= op_store;
                        base_r     <= base_addr;
                        store_r    <= store_data;
                        wrap_r     <= wrap_s;
                        lane_r     <= '0;
                        mem_addr   <= base_addr;
                        mem_wren   <= op_store;
                        mem_rden   <= ~op_store;
                        mem_wdata  <= op_store ? store_data[7:0] : 8'h00;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (lane_r == LW'(LANES - 1)) begin
                        lane_r      <= '0;
                        drain_cnt_r <= 2'd0;
                        mem_addr    <= '0;
                        mem_rden    <= 1'b0;
                        mem_wren    <= 1'b0;
                        mem_wdata   <= 8'h00;
                        if (op_store_r) begin
                            state_r   <= DONE;
                            done      <= 1'b1;
                            addr_wrap <= wrap_r;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else begin
                        lane_r    <= lane_nxt_s;
                        mem_addr  <= base_r + ADDR_W'(lane_nxt_s);
                        mem_wdata <= op_store_r ? store_r[{lane_nxt_s, 3'b000} +: 8] : 8'h00;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == 2'(READ_LAT - 1)) begin
                        state_r   <= DONE;
                        done      <= 1'b1;
                        addr_wrap <= wrap_r;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    addr_wrap <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    addr_wrap <= 1'b0;
                    mem_rden  <= 1'b0;
                    mem_wren  <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            assign cap_vld_s  = mem_rden;
            assign cap_lane_s = lane_r;
        end else begin : g_latn
            logic [READ_LAT-2:0] vld_sr_r;
            logic [LW-1:0]       lane_sr_r [READ_LAT-1];

            // Delay line tracking which lane's read data arrives on mem_q.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    vld_sr_r <= '0;
                    for (int i = 0; i < READ_LAT - 1; i++) lane_sr_r[i] <= '0;
                end else begin
                    vld_sr_r[0]  <= mem_rden;
                    lane_sr_r[0] <= lane_r;
                    for (int i = 1; i < READ_LAT - 1; i++) begin
                        vld_sr_r[i]  <= vld_sr_r[i-1];
                        lane_sr_r[i] <= lane_sr_r[i-1];
                    end
                end
            end

            assign cap_vld_s  = vld_sr_r[READ_LAT-2];
            assign cap_lane_s = lane_sr_r[READ_LAT-2];
        end
    endgenerate

    // Gather returning read bytes into their lanes; stores leave the last load intact.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_data <= '0;
        end else if (cap_vld_s) begin
            load_data[{cap_lane_s, 3'b000} +: 8] <= mem_q;
        end else begin
            load_data <= load_data;
        end
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed scoreboard bench for vec_mem_sequencer with a combinational-read memory model.
module tb_vec_mem_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op_store;
    logic [7:0]  base_addr;
    logic [31:0] store_data;
    logic        busy, done, mem_rden, mem_wren, addr_wrap;
    logic [31:0] load_data;
    logic [7:0]  mem_addr, mem_wdata, mem_q;

    vec_mem_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .op_store(op_store),
        .base_addr(base_addr), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .mem_addr(mem_addr), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_q(mem_q), .addr_wrap(addr_wrap)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [256] = '{default: 8'h00};
    always @(posedge clock) if (mem_wren) mem[mem_addr] <= mem_wdata;
    assign mem_q = mem[mem_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed { logic rd; logic wr; logic [7:0] addr; logic [7:0] wd; logic [31:0] cyc; } acc_t;
    typedef struct packed { logic [31:0] cyc; logic [31:0] ld; logic wrap; } dn_t;
    acc_t q_acc[$];
    dn_t  q_done[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_ld = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_wrap(input logic [7:0] base);
`ifdef VSEQ_WRAP_CHK_EN
        return ({1'b0, base} + 9'd3) > 9'd255;
`else
        return base[0] & 1'b0;
`endif
    endfunction

    // Drive a start at the next edge and queue the expected accesses (nl lanes) and done.
    task automatic xfer(input logic op, input logic [7:0] base, input logic [31:0] data,
                        input logic [31:0] exp_ld, input int nl, output int c0);
        acc_t a;
        dn_t  d;
        start = 1'b1; op_store = op; base_addr = base; store_data = data;
        @(posedge clock); #1;
        start = 1'b0;
        c0 = cyc;
        for (int i = 0; i < nl; i++) begin
            a.rd = ~op; a.wr = op; a.addr = base + 8'(i); a.wd = data[8*i +: 8]; a.cyc = 32'(c0 + i);
            q_acc.push_back(a);
        end
        if (nl == 4) begin
            d.cyc = 32'(c0 + (op ? 4 : 5)); d.ld = exp_ld; d.wrap = exp_wrap(base);
            q_done.push_back(d);
            if (!op) last_ld = exp_ld;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q_acc.size() != 0 || q_done.size() != 0) && n < 60) begin
            @(negedge clock); n++;
        end
        check("idle_timeout", 64'(n < 60), 64'd1);
    endtask

    // Scoreboard monitor: pops expected accesses/done pulses as the DUT produces them.
    always @(negedge clock) begin
        acc_t e;
        dn_t  d;
        if (!reset) begin
            check("rd_wr_excl", 64'(mem_rden & mem_wren), 64'd0);
            if (mem_rden || mem_wren) begin
                check("acc_expected", 64'(q_acc.size() != 0), 64'd1);
                if (q_acc.size() != 0) begin
                    e = q_acc.pop_front();
                    check("acc_kind", {62'd0, mem_rden, mem_wren}, {62'd0, e.rd, e.wr});
                    check("acc_addr", 64'(mem_addr), 64'(e.addr));
                    check("acc_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.wr) check("acc_wdata", 64'(mem_wdata), 64'(e.wd));
                end
            end else begin
                check("idle_addr", 64'(mem_addr), 64'd0);
                check("idle_wdata", 64'(mem_wdata), 64'd0);
            end
            if (done) begin
                check("done_expected", 64'(q_done.size() != 0), 64'd1);
                if (q_done.size() != 0) begin
                    d = q_done.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.cyc));
                    check("load_data", 64'(load_data), 64'(d.ld));
                    check("addr_wrap", 64'(addr_wrap), 64'(d.wrap));
                    check("busy_at_done", 64'(busy), 64'd1);
                end
            end else begin
                check("wrap_without_done", 64'(addr_wrap), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, n;
        reset = 1'b1; start = 1'b0; op_store = 1'b0; base_addr = 8'h00; store_data = 32'h0;
        repeat (2) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_en", {62'd0, mem_rden, mem_wren}, 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_load_data", 64'(load_data), 64'd0);
        check("rst_wrap", 64'(addr_wrap), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: plain store
        xfer(1'b1, 8'h10, 32'hDDCCBBAA, last_ld, 4, c0);
        wait_idle();
        check("st_mem", {32'd0, mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 64'hDDCCBBAA);

        // 2: preload 0x20..0x23 via a store, then load it back
        xfer(1'b1, 8'h20, 32'h04030201, last_ld, 4, c0);
        wait_idle();
        xfer(1'b0, 8'h20, 32'h0, 32'h04030201, 4, c0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            check($sformatf("ld_busy_c%0d", k), 64'(busy), 64'(k <= 6));
        end
        wait_idle();

        // 3: store crossing the top address
        xfer(1'b1, 8'hFE, 32'h44332211, last_ld, 4, c0);
        wait_idle();
        check("wrap_mem", {32'd0, mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]}, 64'h44332211);

        // 4: start pulsed during a load is ignored
        xfer(1'b0, 8'h20, 32'h0, 32'h04030201, 4, c0);
        @(posedge clock); #1;
        start = 1'b1; op_store = 1'b1; base_addr = 8'h40; store_data = 32'h99999999;
        @(posedge clock); #1;
        start = 1'b0;
        wait_idle();
        repeat (8) @(negedge clock);
        check("ignored_store", 64'(mem[8'h40]), 64'd0);

        // 5: reset in the middle of a store
        xfer(1'b1, 8'h30, 32'h88776655, last_ld, 2, c0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_wren", 64'(mem_wren), 64'd0);
        check("mid_rst_load_data", 64'(load_data), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        last_ld = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("partial_mem", {32'd0, mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 64'h00006655);
        check("q_after_rst", 64'(q_acc.size()), 64'd0);
        xfer(1'b1, 8'h30, 32'h0C0B0A09, last_ld, 4, c0);
        wait_idle();
        check("fresh_mem", {32'd0, mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 64'h0C0B0A09);

        // 6: back-to-back loads, second start in the cycle after done
        xfer(1'b0, 8'h20, 32'h0, 32'h04030201, 4, c0);
        n = 0;
        do begin @(negedge clock); n++; end while (!done && n < 20);
        check("b2b_first_done", 64'(done), 64'd1);
        @(posedge clock); #1;
        check("b2b_idle_gap", 64'(busy), 64'd0);
        xfer(1'b0, 8'h10, 32'h0, 32'hDDCCBBAA, 4, c1);
        check("b2b_start_gap", 64'(c1 - c0), 64'd7);
        wait_idle();
        repeat (4) @(negedge clock);

        check("acc_queue_empty", 64'(q_acc.size()), 64'd0);
        check("done_queue_empty", 64'(q_done.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
